// File: rtl/barrel_shifter_r.sv
// Right barrel shifter over 2^N elements of M bits, logical or arithmetic fill.
// A log-stage combinational core feeds one registered output stage with a valid flag.
module barrel_shifter_r #(
  parameter int N = 3,
  parameter int M = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      valid_in,
  input  logic [(1<<N)-1:0][M-1:0]  A,
  input  logic [N-1:0]              shamt,
  input  logic                      arithmetic,
  output logic [(1<<N)-1:0][M-1:0]  Y,
  output logic                      valid_out
);

  localparam int E = 1 << N;
  localparam int W = E * M;

  logic [W-1:0] stage_data [0:N];
  logic         fill;
  logic [W-1:0] y_reg;
  logic         valid_reg;

  // Sign fill comes from the original operand, not from intermediate stages.
  assign fill          = arithmetic & A[E-1][M-1];
  assign stage_data[0] = A;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_stage
      localparam int SH = (1 << gi) * M;
      assign stage_data[gi+1] = shamt[gi]
                              ? {{SH{fill}}, stage_data[gi][W-1:SH]}
                              : stage_data[gi];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      y_reg     <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= valid_in;
      if (valid_in) begin
        y_reg <= stage_data[N];
      end
    end
  end

  assign Y         = y_reg;
  assign valid_out = valid_reg;

endmodule

// File: tb/tb_barrel_shifter_r.sv
// Self-checking bench for barrel_shifter_r at N=3, M=4: directed cases, random sweep, resets.
module tb_barrel_shifter_r;

  logic              clock;
  logic              reset_n;
  logic              valid_in;
  logic [7:0][3:0]   A;
  logic [2:0]        shamt;
  logic              arithmetic;
  logic [7:0][3:0]   Y;
  logic              valid_out;

  int tests_run;
  int tests_failed;

  barrel_shifter_r #(.N(3), .M(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .valid_in   (valid_in),
    .A          (A),
    .shamt      (shamt),
    .arithmetic (arithmetic),
    .Y          (Y),
    .valid_out  (valid_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: whole-element shift expressed as plain bit arithmetic.
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input int s, input logic ar);
    logic signed [31:0] t;
    if (ar) begin
      t = $signed(a);
      t = t >>> (4 * s);
      return t;
    end
    return a >> (4 * s);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [2:0] s, input logic ar, input logic v);
    @(negedge clock);
    A          = a;
    shamt      = s;
    arithmetic = ar;
    valid_in   = v;
  endtask

  task automatic settle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] a_rand;
    logic [31:0] y_prev;
    tests_run    = 0;
    tests_failed = 0;

    // Reset applied before any clock edge with busy inputs.
    reset_n    = 1'b0;
    valid_in   = 1'b1;
    A          = 32'hDEAD_BEEF;
    shamt      = 3'd3;
    arithmetic = 1'b1;
    #1;
    check("reset_y", Y, 32'h0);
    check("reset_valid", {31'b0, valid_out}, 32'h0);
    settle();
    check("reset_hold_y", Y, 32'h0);
    check("reset_hold_valid", {31'b0, valid_out}, 32'h0);

    @(negedge clock);
    reset_n  = 1'b1;
    valid_in = 1'b0;

    drive(32'h8765_4321, 3'd2, 1'b0, 1'b1);
    settle();
    check("srl_2", Y, 32'h0087_6543);
    check("srl_2_valid", {31'b0, valid_out}, 32'h1);
    drive(32'h1111_1111, 3'd5, 1'b1, 1'b0);
    settle();
    check("hold_y", Y, 32'h0087_6543);
    check("hold_valid", {31'b0, valid_out}, 32'h0);

    drive(32'h8765_4321, 3'd2, 1'b1, 1'b1);
    settle();
    check("sra_neg_2", Y, 32'hFF87_6543);
    drive(32'h8765_4321, 3'd7, 1'b1, 1'b1);
    settle();
    check("sra_neg_7", Y, 32'hFFFF_FFF8);
    drive(32'h7654_3210, 3'd7, 1'b1, 1'b1);
    settle();
    check("sra_pos_7", Y, 32'h0000_0007);
    drive(32'h7654_3210, 3'd0, 1'b1, 1'b1);
    settle();
    check("sra_0", Y, 32'h7654_3210);
    drive(32'h7654_3210, 3'd0, 1'b0, 1'b1);
    settle();
    check("srl_0", Y, 32'h7654_3210);
    drive(32'h8765_4321, 3'd7, 1'b0, 1'b1);
    settle();
    check("srl_7", Y, 32'h0000_0008);
    drive(32'h8765_4321, 3'd0, 1'b1, 1'b1);
    settle();
    check("sra_neg_0", Y, 32'h8765_4321);

    // Back-to-back random sweep over every shift amount in both modes.
    for (int i = 0; i < 8; i++) begin
      a_rand = $urandom;
      if (i == 0) a_rand[31] = 1'b1;
      if (i == 1) a_rand[31] = 1'b0;
      for (int j = 0; j < 8; j++) begin
        for (int m = 0; m < 2; m++) begin
          drive(a_rand, 3'(j), 1'(m), 1'b1);
          settle();
          check($sformatf("sweep_a%h_s%0d_m%0d", a_rand, j, m), Y, ref_shift(a_rand, j, 1'(m)));
          check("sweep_valid", {31'b0, valid_out}, 32'h1);
        end
      end
    end

    // Mid-stream reset between two valid captures, away from any edge.
    drive(32'hA5A5_1234, 3'd1, 1'b1, 1'b1);
    settle();
    y_prev = ref_shift(32'hA5A5_1234, 1, 1'b1);
    check("pre_reset_y", Y, y_prev);
    drive(32'h9ABC_DEF0, 3'd3, 1'b1, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_reset_y", Y, 32'h0);
    check("mid_reset_valid", {31'b0, valid_out}, 32'h0);
    settle();
    check("mid_reset_discard", Y, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    settle();
    check("post_release_y", Y, ref_shift(32'h9ABC_DEF0, 3, 1'b1));
    check("post_release_valid", {31'b0, valid_out}, 32'h1);
    drive(32'h9ABC_DEF0, 3'd4, 1'b0, 1'b1);
    settle();
    check("post_release_srl", Y, 32'h0000_9ABC);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
